clk_div_gen: RTL and testbench
==============================

CLK_DIV_GEN -- requirements
Module: clk_div_gen

Interface
REQ-001 Parameter NUM_CH, default 4, SHALL set the number of independent divided-clock channels (1..16).
REQ-002 Parameter DIV_W, default 8, SHALL set the divisor width per channel.
REQ-003 clk  input  1  SHALL be the single block clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  SHALL be a synchronous, active-high reset.
REQ-005 ch_en  input  NUM_CH  SHALL be the per-channel run request, level-sensitive.
REQ-006 div_val  input  NUM_CH*DIV_W  SHALL carry the packed per-channel divisors; channel i SHALL occupy bits [i*DIV_W +: DIV_W].
REQ-007 load  input  NUM_CH  SHALL be the per-channel one-cycle strobe capturing div_val for that channel.
REQ-008 clk_out  output  NUM_CH  SHALL be the registered divided clocks.
REQ-009 tick  output  NUM_CH  SHALL pulse for one cycle, aligned with each clk_out rising edge.
REQ-010 busy  output  NUM_CH  SHALL be high while the channel is not IDLE.

Function
REQ-011 Each channel SHALL hold an active divisor D, a pending divisor P, a pending flag, and a counter cnt (DIV_W bits).
REQ-012 Effective divisor SHALL be max(D,2); values 0 and 1 SHALL be clamped to 2.
REQ-013 Period SHALL be D cycles; clk_out high for H = ceil(D/2) cycles, low for D-H cycles.
REQ-014 Each channel FSM SHALL have three states: IDLE, RUN, STOPPING.
REQ-015 IDLE: cnt=0, clk_out=0, tick=0; ch_en=1 sampled at edge k SHALL move to RUN with clk_out=1, tick=1, cnt=0 visible after edge k.
REQ-016 RUN/STOPPING: cnt SHALL increment each cycle; clk_out SHALL equal (next cnt < H).
REQ-017 At cnt==D-1 in RUN, cnt SHALL wrap to 0, clk_out=1, tick=1.
REQ-018 ch_en=0 in RUN SHALL move to STOPPING; no high phase SHALL be truncated.
REQ-019 STOPPING SHALL finish the current period; at cnt==D-1 it SHALL go to IDLE with clk_out=0 and no tick.
REQ-020 ch_en=1 in STOPPING SHALL return to RUN with no change to cnt or clk_out.
REQ-021 load in IDLE SHALL write D directly.
REQ-022 load in RUN/STOPPING SHALL write P and set pending; at the next wrap, D SHALL take P and pending SHALL clear.
REQ-023 load coincident with the wrap cycle SHALL apply the new value to the period starting at that wrap.
REQ-024 A second load before the wrap SHALL overwrite P; last value wins.
REQ-025 Channels SHALL be fully independent; no cross-channel timing dependency.
REQ-026 busy SHALL be 1 in RUN and STOPPING and 0 in IDLE, registered with the state.

Reset
REQ-027 rst=1 SHALL force all channels to IDLE, with cnt=0, clk_out=0, tick=0, busy=0, D=2, P=2, pending=0, on the next edge.
REQ-028 rst SHALL override ch_en and load in the same cycle.
REQ-029 rst mid-period SHALL drop clk_out to 0 immediately after the edge; the glitch-free rule does not apply to reset.

Verification
REQ-030 Ch0: load D=4, ch_en=1 -> clk_out pattern 1100 repeating (25 MHz from 100 MHz), tick every 4th cycle, busy=1.
REQ-031 Ch1: D=5 -> clk_out 11100 repeating; D=0 and D=1 -> 10 repeating.
REQ-032 Ch2: D=6, drop ch_en at cnt=1 -> clk_out stays 1 through cnt=2, low cnt=3..5, then IDLE with busy=0, no further tick.
REQ-033 Ch3: D=4 running, load D=8 at cnt=1 -> current period completes as 1100, then 11110000 repeating; load at cnt=3 -> the new value applies from the next period.
REQ-034 All channels running with distinct D, assert rst for 1 cycle at arbitrary cnt -> all outputs 0 next cycle; with ch_en held, restart per REQ-015 with D=2.
REQ-035 Drop ch_en and reassert 1 cycle later in STOPPING -> clk_out waveform identical to uninterrupted RUN.

Source files
------------

// File: rtl/clk_div_gen.sv
// clk_div_gen: NUM_CH independent, glitch-free programmable clock dividers.
//
// Each channel divides clk by an effective divisor max(D,2). Its output is high
// for ceil(D/2) cycles and low for the rest of the period. Disabling a channel lets
// the current period finish before the channel goes idle. A divisor loaded while
// the channel is running takes effect at the next period boundary.
//
// Ports:
//   clk      block clock; all state updates on its rising edge
//   rst      synchronous active-high reset
//   ch_en    per-channel run request (level)
//   div_val  packed divisors; channel i at [i*DIV_W +: DIV_W]
//   load     per-channel strobe that captures div_val for that channel
//   clk_out  registered divided clocks
//   tick     one-cycle pulse aligned with each clk_out rising edge
//   busy     high while a channel is running or stopping
module clk_div_gen #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned DIV_W  = 8   // must be >= 2 so the reset divisor 2 fits
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       ch_en,
  input  logic [NUM_CH*DIV_W-1:0] div_val,
  input  logic [NUM_CH-1:0]       load,
  output logic [NUM_CH-1:0]       clk_out,
  output logic [NUM_CH-1:0]       tick,
  output logic [NUM_CH-1:0]       busy
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StStop = 2'd2
  } state_e;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    state_e           state_q;
    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] pend_div_q;
    logic             pend_q;
    logic [DIV_W-1:0] cnt_q;
    logic             clk_q;
    logic             tick_q;
    logic             busy_q;

    logic [DIV_W-1:0] div_in;
    logic [DIV_W-1:0] eff_div;
    logic [DIV_W-1:0] next_div;
    logic [DIV_W:0]   half;
    logic [DIV_W:0]   cnt_inc;
    logic             at_end;
    logic             keep_running;

    assign div_in   = div_val[i*DIV_W +: DIV_W];
    assign eff_div  = (div_q < DIV_W'(2)) ? DIV_W'(2) : div_q;
    // ceil(eff_div / 2), one bit wider so the +1 cannot overflow
    assign half     = ({1'b0, eff_div} + (DIV_W+1)'(1)) >> 1;
    assign cnt_inc  = {1'b0, cnt_q} + (DIV_W+1)'(1);
    assign at_end   = (cnt_q == eff_div - DIV_W'(1));
    // A load on the boundary cycle beats any older pending value
    assign next_div = load[i] ? div_in : (pend_q ? pend_div_q : div_q);
    // RUN keeps going for one more period even if ch_en just dropped; STOPPING
    // resumes as soon as ch_en returns, so the waveform is never disturbed.
    assign keep_running = (state_q == StRun) || ch_en[i];

    always_ff @(posedge clk) begin
      if (rst) begin
        state_q    <= StIdle;
        div_q      <= DIV_W'(2);
        pend_div_q <= DIV_W'(2);
        pend_q     <= 1'b0;
        cnt_q      <= '0;
        clk_q      <= 1'b0;
        tick_q     <= 1'b0;
        busy_q     <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            cnt_q  <= '0;
            pend_q <= 1'b0;
            if (load[i]) div_q <= div_in;
            if (ch_en[i]) begin
              state_q <= StRun;
              clk_q   <= 1'b1;
              tick_q  <= 1'b1;
              busy_q  <= 1'b1;
            end else begin
              clk_q  <= 1'b0;
              tick_q <= 1'b0;
              busy_q <= 1'b0;
            end
          end
          StRun, StStop: begin
            if (at_end) begin
              cnt_q  <= '0;
              div_q  <= next_div;
              pend_q <= 1'b0;
              if (keep_running) begin
                state_q <= ch_en[i] ? StRun : StStop;
                clk_q   <= 1'b1;
                tick_q  <= 1'b1;
                busy_q  <= 1'b1;
              end else begin
                state_q <= StIdle;
                clk_q   <= 1'b0;
                tick_q  <= 1'b0;
                busy_q  <= 1'b0;
              end
            end else begin
              state_q <= ch_en[i] ? StRun : StStop;
              cnt_q   <= cnt_inc[DIV_W-1:0];
              clk_q   <= (cnt_inc < half);
              tick_q  <= 1'b0;
              busy_q  <= 1'b1;
              if (load[i]) begin
                pend_div_q <= div_in;
                pend_q     <= 1'b1;
              end
            end
          end
          default: begin
            state_q <= StIdle;
            cnt_q   <= '0;
            clk_q   <= 1'b0;
            tick_q  <= 1'b0;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end

    assign clk_out[i] = clk_q;
    assign tick[i]    = tick_q;
    assign busy[i]    = busy_q;
  end

endmodule

// File: tb/tb_clk_div_gen.sv
// Self-checking bench for clk_div_gen: directed scenarios followed by random traffic,
// all compared every cycle against a phase-based model of each channel.
module tb_clk_div_gen;
  localparam int NCH = 4;
  localparam int DW  = 8;

  logic              clk;
  logic              rst;
  logic [NCH-1:0]    ch_en;
  logic [NCH*DW-1:0] div_val;
  logic [NCH-1:0]    load;
  logic [NCH-1:0]    clk_out;
  logic [NCH-1:0]    tick;
  logic [NCH-1:0]    busy;

  clk_div_gen #(
    .NUM_CH(NCH),
    .DIV_W (DW)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .ch_en  (ch_en),
    .div_val(div_val),
    .load   (load),
    .clk_out(clk_out),
    .tick   (tick),
    .busy   (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_err;
  int n_checks;

  // Model: a channel is either inactive or at some phase of a period of length
  // max(d,2); outputs follow from the phase alone.
  bit m_act [NCH];
  bit m_stop[NCH];
  int m_ph  [NCH];
  int m_d   [NCH];
  int m_p   [NCH];
  bit m_pend[NCH];

  function automatic int eff(int d);
    return (d < 2) ? 2 : d;
  endfunction

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    assert (got === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_step();
    for (int c = 0; c < NCH; c++) begin
      int v;
      v = int'(div_val[c*DW +: DW]);
      if (rst) begin
        m_act[c] = 0; m_stop[c] = 0; m_ph[c] = 0;
        m_d[c] = 2; m_p[c] = 2; m_pend[c] = 0;
      end else if (!m_act[c]) begin
        if (load[c]) m_d[c] = v;
        if (ch_en[c]) begin
          m_act[c] = 1; m_stop[c] = 0; m_ph[c] = 0;
        end
      end else if (m_ph[c] == eff(m_d[c]) - 1) begin
        if (load[c]) begin
          m_d[c] = v; m_pend[c] = 0;
        end else if (m_pend[c]) begin
          m_d[c] = m_p[c]; m_pend[c] = 0;
        end
        if (m_stop[c] && !ch_en[c]) m_act[c] = 0;
        m_ph[c]   = 0;
        m_stop[c] = !ch_en[c];
      end else begin
        m_ph[c]   = m_ph[c] + 1;
        m_stop[c] = !ch_en[c];
        if (load[c]) begin
          m_p[c] = v; m_pend[c] = 1;
        end
      end
    end
  endtask

  task automatic step();
    logic [NCH-1:0] e_clk, e_tick, e_busy;
    @(posedge clk);
    model_step();
    #1;
    for (int c = 0; c < NCH; c++) begin
      e_busy[c] = m_act[c];
      e_tick[c] = m_act[c] && (m_ph[c] == 0);
      e_clk[c]  = m_act[c] && (m_ph[c] < (eff(m_d[c]) + 1) / 2);
    end
    chk("clk_out", 32'(clk_out), 32'(e_clk));
    chk("tick", 32'(tick), 32'(e_tick));
    chk("busy", 32'(busy), 32'(e_busy));
  endtask

  task automatic set_div(int c, int v);
    div_val[c*DW +: DW] = DW'(v);
  endtask

  logic [9:0] pat0, pat1, tpat0;
  logic [4:0] pat2, bpat2;

  initial begin
    n_err = 0;
    n_checks = 0;
    for (int c = 0; c < NCH; c++) begin
      m_act[c] = 0; m_stop[c] = 0; m_ph[c] = 0;
      m_d[c] = 2; m_p[c] = 2; m_pend[c] = 0;
    end
    rst = 1'b1; ch_en = '0; load = '0; div_val = '0;
    step();
    step();
    chk("reset_clk_out", 32'(clk_out), 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);
    rst = 1'b0;
    step();

    // Ch0 D=4 and ch1 D=5 started together
    set_div(0, 4); set_div(1, 5);
    load = 4'b0011; ch_en = 4'b0011;
    step();
    load = '0;
    pat0 = '0; pat1 = '0; tpat0 = '0;
    for (int k = 0; k < 10; k++) begin
      if (k > 0) step();
      pat0  = {pat0[8:0], clk_out[0]};
      pat1  = {pat1[8:0], clk_out[1]};
      tpat0 = {tpat0[8:0], tick[0]};
    end
    chk("ch0_d4_wave", 32'(pat0), 32'(10'b1100110011));
    chk("ch0_d4_tick", 32'(tpat0), 32'(10'b1000100010));
    chk("ch1_d5_wave", 32'(pat1), 32'(10'b1110011100));

    // Ch1 retargeted to 0 then 1 (both clamp to 2)
    set_div(1, 0); load = 4'b0010;
    step();
    load = '0;
    repeat (8) step();
    set_div(1, 1); load = 4'b0010;
    step();
    load = '0;
    repeat (8) step();

    // Ch2 D=6, ch_en dropped while cnt=1
    set_div(2, 6); load = 4'b0100; ch_en[2] = 1'b1;
    step();
    load = '0;
    step();
    ch_en[2] = 1'b0;
    pat2 = '0; bpat2 = '0;
    for (int k = 0; k < 5; k++) begin
      step();
      pat2  = {pat2[3:0], clk_out[2]};
      bpat2 = {bpat2[3:0], busy[2]};
    end
    chk("ch2_stop_wave", 32'(pat2), 32'(5'b10000));
    chk("ch2_stop_busy", 32'(bpat2), 32'(5'b11110));
    repeat (6) step();
    chk("ch2_idle_tick", 32'(tick[2]), 32'h0);

    // Ch3 D=4, reload to 8 while cnt=1
    set_div(3, 4); load = 4'b1000; ch_en[3] = 1'b1;
    step();
    load = '0;
    step();
    set_div(3, 8); load = 4'b1000;
    pat1 = '0;
    for (int k = 0; k < 10; k++) begin
      step();
      load = '0;
      pat1 = {pat1[8:0], clk_out[3]};
    end
    chk("ch3_reload_wave", 32'(pat1), 32'(10'b0011110000));
    // Reload on the boundary cycle: wait for the last count of the period
    for (int k = 0; k < 8 && !(m_ph[3] == 7); k++) step();
    set_div(3, 3); load = 4'b1000;
    step();
    load = '0;
    repeat (9) step();

    // Ch0 briefly disabled: the waveform must not change
    ch_en[0] = 1'b0;
    step();
    ch_en[0] = 1'b1;
    pat0 = '0;
    for (int k = 0; k < 8; k++) begin
      step();
      pat0 = {pat0[8:0], clk_out[0]};
    end

    // All running, one-cycle reset, restart at D=2
    ch_en = 4'b1111;
    repeat (3) step();
    rst = 1'b1; load = 4'b1111;
    step();
    rst = 1'b0; load = '0;
    chk("rst_mid_clk_out", 32'(clk_out), 32'h0);
    chk("rst_mid_tick", 32'(tick), 32'h0);
    step();
    chk("restart_clk_out", 32'(clk_out), 32'hf);
    step();
    chk("restart_d2_low", 32'(clk_out), 32'h0);

    // Random traffic
    for (int n = 0; n < 800; n++) begin
      rst = ($urandom_range(63) == 0);
      for (int c = 0; c < NCH; c++) begin
        if ($urandom_range(7) == 0) ch_en[c] = ~ch_en[c];
        load[c] = ($urandom_range(11) == 0);
        set_div(c, int'($urandom_range(9)));
      end
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
